// File: rtl/seq_lane_pkg.sv
// Shared lane definitions for the w/x/y serial pattern generator and detector.
// Frame patterns, lane select encodings and the generator state encoding.
package seq_lane_pkg;

   localparam logic [3:0] W_PAT = 4'b1010;
   localparam logic [3:0] X_PAT = 4'b1110;
   localparam logic [3:0] Y_PAT = 4'b1000;

   localparam logic [1:0] SEL_W   = 2'd0;
   localparam logic [1:0] SEL_X   = 2'd1;
   localparam logic [1:0] SEL_Y   = 2'd2;
   localparam logic [1:0] SEL_ALL = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_GAP  = 2'd2,
      ST_FIN  = 2'd3
   } state_e;

   // Returns {y, x, w} for frame bit idx of the selected lane(s).
   function automatic logic [2:0] lane_bits(input logic [1:0] sel, input logic [1:0] idx);
      logic [2:0] r;
      r = 3'b000;
      case (sel)
         SEL_W:   r = {1'b0, 1'b0, W_PAT[idx]};
         SEL_X:   r = {1'b0, X_PAT[idx], 1'b0};
         SEL_Y:   r = {Y_PAT[idx], 1'b0, 1'b0};
         SEL_ALL: r = {Y_PAT[idx], X_PAT[idx], W_PAT[idx]};
         default: r = 3'b000;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/sequence_generator.sv
// Serialises repeated 4-bit lane frames (MSB first) with trailing zero gaps.
// One request (lane select, repetition count) is accepted per valid/ready handshake.
module sequence_generator
   import seq_lane_pkg::*;
#(
   parameter int CNT_W = 4,
   parameter int GAP   = 2
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [1:0]       req_sel,
   input  logic [CNT_W-1:0] req_count,
   output logic             w,
   output logic             x,
   output logic             y,
   output logic             busy,
   output logic             done
);

   localparam bit         GAP_EN   = (GAP > 0);
   localparam logic [3:0] GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

   state_e             state_q, state_d;
   logic [1:0]         bit_q, bit_d;
   logic [3:0]         gap_q, gap_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [1:0]         sel_q, sel_d;
   logic [2:0]         lane_q, lane_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               ready_s;
   logic               accept_s;
   logic [CNT_W-1:0]   cnt_dec_s;

   assign ready_s   = (state_q == ST_IDLE) || (state_q == ST_FIN);
   assign accept_s  = req_valid & ready_s & ~reset;
   // Saturating decrement: the remaining count never wraps below zero.
   assign cnt_dec_s = (cnt_q != {CNT_W{1'b0}}) ? (cnt_q - CNT_W'(1'b1)) : {CNT_W{1'b0}};

   // State, counters and output flops.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         bit_q   <= 2'd0;
         gap_q   <= 4'd0;
         cnt_q   <= {CNT_W{1'b0}};
         sel_q   <= 2'd0;
         lane_q  <= 3'b000;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         bit_q   <= bit_d;
         gap_q   <= gap_d;
         cnt_q   <= cnt_d;
         sel_q   <= sel_d;
         lane_q  <= lane_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Next-state and counter sequencing.
   always_comb begin
      state_d = state_q;
      bit_d   = bit_q;
      gap_d   = gap_q;
      cnt_d   = cnt_q;
      sel_d   = sel_q;
      case (state_q)
         ST_IDLE, ST_FIN: begin
            if (accept_s) begin
               sel_d = req_sel;
               cnt_d = req_count;
               bit_d = 2'd3;
               gap_d = 4'd0;
               if (req_count != {CNT_W{1'b0}}) begin
                  state_d = ST_SEND;
               end else begin
                  state_d = ST_FIN;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SEND: begin
            if (bit_q != 2'd0) begin
               bit_d = bit_q - 2'd1;
            end else if (GAP_EN) begin
               state_d = ST_GAP;
               gap_d   = GAP_LAST;
            end else begin
               cnt_d = cnt_dec_s;
               bit_d = 2'd3;
               if (cnt_dec_s != {CNT_W{1'b0}}) begin
                  state_d = ST_SEND;
               end else begin
                  state_d = ST_FIN;
               end
            end
         end
         ST_GAP: begin
            if (gap_q != 4'd0) begin
               gap_d = gap_q - 4'd1;
            end else begin
               cnt_d = cnt_dec_s;
               bit_d = 2'd3;
               if (cnt_dec_s != {CNT_W{1'b0}}) begin
                  state_d = ST_SEND;
               end else begin
                  state_d = ST_FIN;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Outputs are decoded from the upcoming state so the flops present them in that cycle.
   always_comb begin
      lane_d = 3'b000;
      busy_d = 1'b0;
      done_d = 1'b0;
      case (state_d)
         ST_SEND: begin
            lane_d = lane_bits(sel_d, bit_d);
            busy_d = 1'b1;
         end
         ST_GAP: begin
            busy_d = 1'b1;
         end
         ST_FIN: begin
            done_d = 1'b1;
         end
         default: begin
            lane_d = 3'b000;
         end
      endcase
   end

   assign req_ready = ready_s;
   assign w         = lane_q[0];
   assign x         = lane_q[1];
   assign y         = lane_q[2];
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_sequence_generator.sv
// Directed bench for sequence_generator: a GAP=2 instance and a GAP=0 instance.
module tb_sequence_generator;

   logic       clk = 1'b0;
   logic       reset;
   logic       req_valid, req_valid_g0;
   logic [1:0] req_sel;
   logic [3:0] req_count;
   logic       rdy_a, w_a, x_a, y_a, busy_a, done_a;
   logic       rdy_b, w_b, x_b, y_b, busy_b, done_b;

   int checks   = 0;
   int failures = 0;

   logic [31:0] tw, tx, ty, td, tr;
   int          tbusy;

   typedef struct {
      logic [1:0]  sel;
      logic [3:0]  cnt;
      bit          g0;
      int          n;
      bit          scr;
      logic [31:0] ew;
      logic [31:0] ex;
      logic [31:0] ey;
      int          ebusy;
   } vec_t;

   vec_t vecs[7];

   always #5 clk = ~clk;

   sequence_generator #(.CNT_W(4), .GAP(2)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy_a),
      .req_sel(req_sel), .req_count(req_count),
      .w(w_a), .x(x_a), .y(y_a), .busy(busy_a), .done(done_a)
   );

   sequence_generator #(.CNT_W(4), .GAP(0)) dut_g0 (
      .clk(clk), .reset(reset), .req_valid(req_valid_g0), .req_ready(rdy_b),
      .req_sel(req_sel), .req_count(req_count),
      .w(w_b), .x(x_b), .y(y_b), .busy(busy_b), .done(done_b)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic clear_trace();
      tw = 32'd0; tx = 32'd0; ty = 32'd0; td = 32'd0; tr = 32'd0; tbusy = 0;
   endtask

   task automatic sample(input bit g0);
      if (g0) begin
         tw = {tw[30:0], w_b}; tx = {tx[30:0], x_b}; ty = {ty[30:0], y_b};
         td = {td[30:0], done_b}; tr = {tr[30:0], rdy_b}; tbusy += int'(busy_b);
      end else begin
         tw = {tw[30:0], w_a}; tx = {tx[30:0], x_a}; ty = {ty[30:0], y_a};
         td = {td[30:0], done_a}; tr = {tr[30:0], rdy_a}; tbusy += int'(busy_a);
      end
   endtask

   // Issue one request from idle, capture n cycles after acceptance, then compare.
   task automatic apply_vec(input vec_t v, input string tag);
      clear_trace();
      @(negedge clk);
      req_sel   = v.sel;
      req_count = v.cnt;
      if (v.g0) req_valid_g0 = 1'b1;
      else      req_valid    = 1'b1;
      chk({tag, "_ready_pre"}, {31'd0, (v.g0 ? rdy_b : rdy_a)}, 32'd1);
      @(posedge clk);
      for (int i = 1; i <= v.n; i++) begin
         @(negedge clk);
         sample(v.g0);
         if (v.scr && i < v.n - 1) begin
            req_sel   = 2'($urandom);
            req_count = 4'($urandom);
         end else begin
            req_valid    = 1'b0;
            req_valid_g0 = 1'b0;
         end
      end
      chk({tag, "_w"}, tw, v.ew);
      chk({tag, "_x"}, tx, v.ex);
      chk({tag, "_y"}, ty, v.ey);
      chk({tag, "_done"}, td, 32'd1);
      chk({tag, "_ready"}, tr, 32'd1);
      chk({tag, "_busy"}, 32'(tbusy), 32'(v.ebusy));
      @(negedge clk);
      chk({tag, "_idle_done"}, {31'd0, (v.g0 ? done_b : done_a)}, 32'd0);
   endtask

   initial begin
      vecs[0] = '{sel: 2'd0, cnt: 4'd1, g0: 1'b0, n: 7,  scr: 1'b0,
                  ew: 32'h50, ex: 32'h0, ey: 32'h0, ebusy: 6};
      vecs[1] = '{sel: 2'd1, cnt: 4'd2, g0: 1'b0, n: 13, scr: 1'b0,
                  ew: 32'h0, ex: 32'h1C70, ey: 32'h0, ebusy: 12};
      vecs[2] = '{sel: 2'd2, cnt: 4'd1, g0: 1'b0, n: 7,  scr: 1'b0,
                  ew: 32'h0, ex: 32'h0, ey: 32'h40, ebusy: 6};
      vecs[3] = '{sel: 2'd3, cnt: 4'd1, g0: 1'b0, n: 7,  scr: 1'b0,
                  ew: 32'h50, ex: 32'h70, ey: 32'h40, ebusy: 6};
      vecs[4] = '{sel: 2'd1, cnt: 4'd0, g0: 1'b0, n: 1,  scr: 1'b0,
                  ew: 32'h0, ex: 32'h0, ey: 32'h0, ebusy: 0};
      vecs[5] = '{sel: 2'd0, cnt: 4'd3, g0: 1'b0, n: 19, scr: 1'b1,
                  ew: 32'h51450, ex: 32'h0, ey: 32'h0, ebusy: 18};
      vecs[6] = '{sel: 2'd3, cnt: 4'd2, g0: 1'b1, n: 9,  scr: 1'b0,
                  ew: 32'h154, ex: 32'h1DC, ey: 32'h110, ebusy: 8};

      reset        = 1'b1;
      req_valid    = 1'b0;
      req_valid_g0 = 1'b0;
      req_sel      = 2'd0;
      req_count    = 4'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_lanes_a", {29'd0, y_a, x_a, w_a}, 32'd0);
      chk("rst_busy_done_a", {30'd0, busy_a, done_a}, 32'd0);
      chk("rst_ready_a", {31'd0, rdy_a}, 32'd1);
      chk("rst_ready_b", {31'd0, rdy_b}, 32'd1);
      reset = 1'b0;

      for (int k = 0; k < 7; k++) begin
         apply_vec(vecs[k], $sformatf("vec%0d", k));
      end

      // Back-to-back: second request accepted in the FIN cycle of the first.
      clear_trace();
      @(negedge clk);
      req_sel = 2'd2; req_count = 4'd1; req_valid = 1'b1;
      @(posedge clk);
      for (int i = 1; i <= 14; i++) begin
         @(negedge clk);
         sample(1'b0);
         if (i == 1) begin
            req_sel = 2'd0; req_count = 4'd1;
         end
         if (i == 8) req_valid = 1'b0;
      end
      chk("b2b_y", ty, 32'h2000);
      chk("b2b_w", tw, 32'h50);
      chk("b2b_x", tx, 32'h0);
      chk("b2b_done", td, 32'h81);
      chk("b2b_ready", tr, 32'h81);
      chk("b2b_busy", 32'(tbusy), 32'd12);
      @(negedge clk);

      // Reset during bit 2 of frame 1.
      clear_trace();
      @(negedge clk);
      req_sel = 2'd0; req_count = 4'd3; req_valid = 1'b1;
      @(posedge clk);
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         sample(1'b0);
         if (i == 1) req_valid = 1'b0;
      end
      chk("mid_w", tw, 32'hA2);
      chk("mid_busy", {31'd0, busy_a}, 32'd1);
      #1 reset = 1'b1;
      #1;
      chk("arst_lanes", {29'd0, y_a, x_a, w_a}, 32'd0);
      chk("arst_busy_done", {30'd0, busy_a, done_a}, 32'd0);
      chk("arst_ready", {31'd0, rdy_a}, 32'd1);
      req_sel = 2'd1; req_count = 4'd1; req_valid = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0; req_valid = 1'b0;
      @(negedge clk);
      chk("post_rst_busy", {31'd0, busy_a}, 32'd0);
      chk("post_rst_x", {31'd0, x_a}, 32'd0);
      chk("post_rst_ready", {31'd0, rdy_a}, 32'd1);
      apply_vec(vecs[0], "after_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
